// File: rtl/filter_dataflow_ctrl.sv
// Dataflow controller for a line-buffered 2D filter: streams one frame of pixels,
// flushes the line buffer for the bottom border, then drains the filter pipeline.
module filter_dataflow_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int WIDTH_IMG  = 255,
   parameter int HEIGHT_IMG = 255,
   parameter int PIPE_LAT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  sel_line1,
   output logic                  sel_line2,
   output logic                  enable,
   output logic                  data_valid_in,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CW = $clog2(WIDTH_IMG) + 1;
   localparam int RW = $clog2(HEIGHT_IMG) + 1;
   localparam int FW = $clog2(WIDTH_IMG + 1) + 1;
   localparam int DW = $clog2(PIPE_LAT) + 1;
   localparam int PW = $clog2(WIDTH_IMG * HEIGHT_IMG + WIDTH_IMG + 2) + 1;

   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_IMG - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_IMG - 1);
   localparam logic [FW-1:0] FL_LAST  = FW'(WIDTH_IMG);
   localparam logic [DW-1:0] DR_LAST  = DW'(PIPE_LAT - 1);
   localparam logic [PW-1:0] PUSH_WV  = PW'(WIDTH_IMG + 1);
   localparam logic [PW-1:0] PUSH_MAX = PW'(WIDTH_IMG * HEIGHT_IMG + WIDTH_IMG + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FLUSH  = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [FW-1:0]         fl_q, fl_d;
   logic [DW-1:0]         dr_q, dr_d;
   logic [PW-1:0]         push_q, push_d;
   logic [PIPE_LAT-1:0]   sr_q, sr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  en_q, en_d;
   logic                  sel1_q, sel1_d;
   logic                  sel2_q, sel2_d;
   logic                  ov_q, ov_d;
   logic                  fd_q, fd_d;
   logic                  s_ready_q, s_ready_d;
   logic                  busy_q, busy_d;

   logic start_s, xfer_s, flush_s, drain_s, last_pix_s, adv_s, wv_s;

   assign start_s    = (state_q == S_IDLE) && start;
   assign xfer_s     = (state_q == S_STREAM) && s_valid;
   assign flush_s    = (state_q == S_FLUSH);
   assign drain_s    = (state_q == S_DRAIN);
   assign last_pix_s = (col_q == COL_LAST) && (row_q == ROW_LAST);

   // Next-state logic for the frame sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_STREAM;
            else       state_d = S_IDLE;
         end
         S_STREAM: begin
            if (xfer_s && last_pix_s) state_d = S_FLUSH;
            else                      state_d = S_STREAM;
         end
         S_FLUSH: begin
            if (fl_q == FL_LAST) state_d = S_DRAIN;
            else                 state_d = S_FLUSH;
         end
         S_DRAIN: begin
            if (dr_q == DR_LAST) state_d = S_IDLE;
            else                 state_d = S_DRAIN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counters, pixel register, strobes and the out_valid delay line
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      fl_d   = fl_q;
      dr_d   = dr_q;
      push_d = push_q;
      sr_d   = sr_q;
      data_d = data_q;
      sel1_d = 1'b0;
      sel2_d = flush_s;
      en_d   = xfer_s || flush_s;
      // Drain cycles keep the delay line moving so the last results surface.
      adv_s  = en_d || drain_s;
      wv_s   = en_d && (push_q >= PUSH_WV);
      ov_d   = 1'b0;
      fd_d   = drain_s && (dr_q == DR_LAST);

      if (start_s) begin
         col_d  = '0;
         row_d  = '0;
         fl_d   = '0;
         dr_d   = '0;
         push_d = '0;
         sr_d   = '0;
      end else if (xfer_s) begin
         data_d = s_data;
         sel1_d = (row_q == '0);
         if (col_q != COL_LAST) begin
            col_d = col_q + CW'(1);
         end else if (row_q != ROW_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q;
         end
      end else if (flush_s) begin
         if (fl_q != FL_LAST) fl_d = fl_q + FW'(1);
         else                 fl_d = fl_q;
      end else if (drain_s) begin
         if (dr_q != DR_LAST) dr_d = dr_q + DW'(1);
         else                 dr_d = dr_q;
      end else begin
         data_d = data_q;
      end

      if (en_d && (push_q != PUSH_MAX)) push_d = push_q + PW'(1);
      else                              push_d = push_d;

      if (adv_s && !start_s) begin
         ov_d    = sr_q[PIPE_LAT-1];
         sr_d[0] = wv_s;
         for (int i = 1; i < PIPE_LAT; i++) begin
            sr_d[i] = sr_q[i-1];
         end
      end else begin
         ov_d = 1'b0;
      end

      s_ready_d = (state_d == S_STREAM);
      busy_d    = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any frame without a done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         fl_q      <= '0;
         dr_q      <= '0;
         push_q    <= '0;
         sr_q      <= '0;
         data_q    <= '0;
         en_q      <= 1'b0;
         sel1_q    <= 1'b0;
         sel2_q    <= 1'b0;
         ov_q      <= 1'b0;
         fd_q      <= 1'b0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         fl_q      <= fl_d;
         dr_q      <= dr_d;
         push_q    <= push_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         en_q      <= en_d;
         sel1_q    <= sel1_d;
         sel2_q    <= sel2_d;
         ov_q      <= ov_d;
         fd_q      <= fd_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
      end
   end

   assign s_ready       = s_ready_q;
   assign data_out      = data_q;
   assign sel_line1     = sel1_q;
   assign sel_line2     = sel2_q;
   assign enable        = en_q;
   assign data_valid_in = en_q;
   assign out_valid     = ov_q;
   assign busy          = busy_q;
   assign frame_done    = fd_q;

endmodule

// File: tb/tb_filter_dataflow_ctrl.sv
// Bench for filter_dataflow_ctrl: frame-level reference model compared every cycle,
// plus per-frame pulse totals checked against hand-computed numbers.
module tb_filter_dataflow_ctrl;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int L  = 2;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic [DW-1:0] data_out;
   logic          sel_line1;
   logic          sel_line2;
   logic          enable;
   logic          data_valid_in;
   logic          out_valid;
   logic          busy;
   logic          frame_done;

   filter_dataflow_ctrl #(
      .DATA_WIDTH (DW),
      .WIDTH_IMG  (W),
      .HEIGHT_IMG (H),
      .PIPE_LAT   (L)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_ready       (s_ready),
      .data_out      (data_out),
      .sel_line1     (sel_line1),
      .sel_line2     (sel_line2),
      .enable        (enable),
      .data_valid_in (data_valid_in),
      .out_valid     (out_valid),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: frame phase plus plain counts of accepted pixels and pipeline advances.
   int m_ph, m_n, m_f, m_d, m_adv;
   int m_en, m_sel1, m_sel2, m_dout, m_ov, m_fd, m_busy, m_srdy, m_xfer;

   // Per-frame observations of the DUT.
   int en_cnt, ov_cnt, fd_cnt, s1_cnt, s2_cnt, rdy_cnt, first_dout, flush_dout;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_n = 0; m_f = 0; m_d = 0; m_adv = 0;
      m_en = 0; m_sel1 = 0; m_sel2 = 0; m_dout = 0; m_ov = 0;
      m_fd = 0; m_busy = 0; m_srdy = 0; m_xfer = 0;
   endtask

   task automatic model_step();
      int adv;
      m_xfer = (m_ph == 1 && s_valid) ? 1 : 0;
      m_en   = (m_xfer == 1 || m_ph == 2) ? 1 : 0;
      m_sel1 = (m_xfer == 1 && m_n < W) ? 1 : 0;
      m_sel2 = (m_ph == 2) ? 1 : 0;
      if (m_xfer == 1) m_dout = int'(s_data);
      adv = (m_en == 1 || m_ph == 3) ? 1 : 0;
      if (adv == 1) m_adv++;
      // Result of the k-th window push appears L advances later; pushes 1..W+1 only prime the window.
      m_ov = (adv == 1 && (m_adv - L) >= W + 2) ? 1 : 0;
      m_fd = 0;
      case (m_ph)
         0: if (start) begin m_ph = 1; m_n = 0; m_adv = 0; end
         1: if (m_xfer == 1) begin
               m_n++;
               if (m_n == W * H) begin m_ph = 2; m_f = 0; end
            end
         2: begin m_f++; if (m_f == W + 1) begin m_ph = 3; m_d = 0; end end
         3: begin m_d++; if (m_d == L) begin m_ph = 0; m_fd = 1; end end
         default: m_ph = 0;
      endcase
      m_busy = (m_ph != 0) ? 1 : 0;
      m_srdy = (m_ph == 1) ? 1 : 0;
   endtask

   task automatic compare_all();
      chk("s_ready",       int'(s_ready),       m_srdy);
      chk("busy",          int'(busy),          m_busy);
      chk("enable",        int'(enable),        m_en);
      chk("data_valid_in", int'(data_valid_in), m_en);
      chk("sel_line1",     int'(sel_line1),     m_sel1);
      chk("sel_line2",     int'(sel_line2),     m_sel2);
      chk("data_out",      int'(data_out),      m_dout);
      chk("out_valid",     int'(out_valid),     m_ov);
      chk("frame_done",    int'(frame_done),    m_fd);
      if (enable)     en_cnt++;
      if (out_valid)  ov_cnt++;
      if (frame_done) fd_cnt++;
      if (sel_line1)  s1_cnt++;
      if (sel_line2)  begin s2_cnt++; flush_dout = int'(data_out); end
      if (s_ready)    rdy_cnt++;
      if (enable && first_dout < 0) first_dout = int'(data_out);
   endtask

   task automatic step(input logic st, input logic sv, input logic [DW-1:0] sd);
      start   = st;
      s_valid = sv;
      s_data  = sd;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},       int'(busy),          0);
      chk({tag, "_s_ready"},    int'(s_ready),       0);
      chk({tag, "_enable"},     int'(enable),        0);
      chk({tag, "_dvi"},        int'(data_valid_in), 0);
      chk({tag, "_sel1"},       int'(sel_line1),     0);
      chk({tag, "_sel2"},       int'(sel_line2),     0);
      chk({tag, "_out_valid"},  int'(out_valid),     0);
      chk({tag, "_frame_done"}, int'(frame_done),    0);
      chk({tag, "_data_out"},   int'(data_out),      0);
   endtask

   task automatic run_frame(input bit toggle, input bit restart6, input bit abort7);
      int  pix;
      int  cyc;
      logic sv;
      en_cnt = 0; ov_cnt = 0; fd_cnt = 0; s1_cnt = 0; s2_cnt = 0; rdy_cnt = 0;
      first_dout = -1; flush_dout = -1;
      pix = 1;
      cyc = 0;
      step(1'b1, 1'b0, 8'd0);
      while (m_ph != 0 && cyc < 300) begin
         sv = toggle ? ((cyc % 2) == 0) : 1'b1;
         step((restart6 && pix == 6) ? 1'b1 : 1'b0, sv, DW'(pix));
         if (m_xfer == 1) pix++;
         cyc++;
         if (abort7 && pix == 8) begin
            rst = 1'b1;
            #1;
            check_all_zero("abort");
            model_reset();
            @(posedge clk);
            #1;
            chk("abort_no_done", int'(frame_done), 0);
            chk("abort_done_cnt", fd_cnt, 0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
      end
      chk("frame_in_budget", (cyc < 300) ? 1 : 0, 1);
      chk("enable_total",    en_cnt, W * H + W + 1);
      chk("out_valid_total", ov_cnt, W * H);
      chk("frame_done_cnt",  fd_cnt, 1);
      chk("sel_line1_cnt",   s1_cnt, W);
      chk("sel_line2_cnt",   s2_cnt, W + 1);
      chk("first_pixel",     first_dout, 1);
      chk("flush_pixel",     flush_dout, W * H);
      if (!toggle) chk("s_ready_cycles", rdy_cnt, W * H);
      step(1'b0, 1'b0, 8'd0);
      chk("busy_after", int'(busy), 0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (3) step(1'b0, 1'b1, 8'hAA);

      run_frame(1'b0, 1'b0, 1'b0);
      run_frame(1'b1, 1'b0, 1'b0);
      run_frame(1'b0, 1'b1, 1'b0);
      run_frame(1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 8'd0);
      run_frame(1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
